// File: rtl/bcd_seg_scanner.sv
// Binary-to-BCD converter (shift-and-add-3) feeding a multiplexed common-anode 7-segment scanner.
// Conversion takes BIN_W+1 cycles with busy high; load is dropped while busy, and the scanner never stalls.
module bcd_seg_scanner #(
   parameter int DIGITS   = 4,
   parameter int BIN_W    = 14,
   parameter int SCAN_DIV = 50000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [BIN_W-1:0]  bin_in,
   input  logic              load,
   input  logic              lzb,
   output logic              busy,
   output logic              done,
   output logic              overflow,
   output logic [DIGITS-1:0] an,
   output logic [7:0]        seg
);

   localparam int BW = DIGITS * 4;
   localparam int CW = $clog2(BIN_W + 1);
   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   function automatic logic [32:0] pow10(input int n);
      logic [32:0] r;
      r = 33'd1;
      for (int i = 0; i < n; i++) r = r * 33'd10;
      return r;
   endfunction

   localparam logic [32:0] LIMIT = pow10(DIGITS);

   function automatic logic [7:0] seg_decode(input logic [3:0] nib);
      logic [7:0] s;
      case (nib)
         4'd0:    s = 8'hC0;
         4'd1:    s = 8'hF9;
         4'd2:    s = 8'hA4;
         4'd3:    s = 8'hB0;
         4'd4:    s = 8'h99;
         4'd5:    s = 8'h92;
         4'd6:    s = 8'h82;
         4'd7:    s = 8'hF8;
         4'd8:    s = 8'h80;
         4'd9:    s = 8'h90;
         default: s = 8'hFF;
      endcase
      return s;
   endfunction

   typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

   state_t            state, state_nxt;
   logic [BIN_W-1:0]  bin_sr;
   logic [BW-1:0]     bcd, bcd_adj, disp;
   logic [CW-1:0]     cnt;
   logic              ovf_next;

   logic [PW-1:0]     presc;
   logic [IW-1:0]     idx;
   logic [3:0]        nib_sel;
   logic              blank;
   logic [7:0]        seg_nxt;
   logic [DIGITS-1:0] an_nxt;

   assign busy = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (load) state_nxt = SHIFT;
         SHIFT:   if (cnt == CW'(1)) state_nxt = COMMIT;
         COMMIT:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bcd_adj = bcd;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bin_sr   <= '0;
         bcd      <= '0;
         cnt      <= '0;
         ovf_next <= 1'b0;
         disp     <= '0;
         overflow <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (load) begin
                  bin_sr   <= bin_in;
                  bcd      <= '0;
                  cnt      <= CW'(BIN_W);
                  ovf_next <= (33'(bin_in) >= LIMIT);
               end
            end
            SHIFT: begin
               // Carry out of the top nibble is dropped; ovf_next alone flags overflow.
               bcd    <= {bcd_adj[BW-2:0], bin_sr[BIN_W-1]};
               bin_sr <= bin_sr << 1;
               cnt    <= cnt - CW'(1);
            end
            COMMIT: begin
               disp     <= bcd;
               overflow <= ovf_next;
               done     <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Walk digits from the top so blanking knows whether everything above is zero.
   always_comb begin
      logic run;
      run     = 1'b1;
      nib_sel = '0;
      blank   = 1'b0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         run = run & (disp[i*4 +: 4] == 4'd0);
         if (idx == IW'(i)) begin
            nib_sel = disp[i*4 +: 4];
            blank   = run && (i != 0);
         end
      end
      if (overflow)          seg_nxt = 8'hBF;
      else if (lzb && blank) seg_nxt = 8'hFF;
      else                   seg_nxt = seg_decode(nib_sel);
      an_nxt = ~(DIGITS'(1) << idx);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc <= '0;
         idx   <= '0;
         an    <= ~DIGITS'(1);
         seg   <= 8'hC0;
      end else begin
         if (presc == PW'(SCAN_DIV - 1)) begin
            presc <= '0;
            idx   <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
         end else begin
            presc <= presc + PW'(1);
         end
         an  <= an_nxt;
         seg <= seg_nxt;
      end
   end

endmodule

// File: tb/tb_bcd_seg_scanner.sv
// Directed and randomized checks of bcd_seg_scanner against an arithmetic display model.
module tb_bcd_seg_scanner;

   localparam int DIGITS   = 4;
   localparam int BIN_W    = 14;
   localparam int SCAN_DIV = 4;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [BIN_W-1:0]  bin_in = '0;
   logic              load = 1'b0;
   logic              lzb = 1'b0;
   logic              busy, done, overflow;
   logic [DIGITS-1:0] an;
   logic [7:0]        seg;

   int checks = 0;
   int errors = 0;
   int ncyc = 0;
   int done_cnt = 0;
   int mval = 0;
   bit movf = 1'b0;

   bcd_seg_scanner #(.DIGITS(DIGITS), .BIN_W(BIN_W), .SCAN_DIV(SCAN_DIV)) dut (
      .clk(clk), .rst_n(rst_n), .bin_in(bin_in), .load(load), .lzb(lzb),
      .busy(busy), .done(done), .overflow(overflow), .an(an), .seg(seg)
   );

   always #5 clk = ~clk;

   // Edges seen since reset release; drives the expected scan position.
   always @(posedge clk) begin
      if (!rst_n) ncyc <= 0;
      else        ncyc <= ncyc + 1;
   end

   always @(negedge clk) begin
      if (done) done_cnt <= done_cnt + 1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   function automatic logic [7:0] digit_seg(input int d);
      logic [7:0] tab [10];
      tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
      return tab[d];
   endfunction

   function automatic logic [7:0] exp_seg(input int value, input bit ovf, input bit lz, input int pos);
      int p;
      if (ovf) return 8'hBF;
      p = 1;
      for (int i = 0; i < pos; i++) p = p * 10;
      if (lz && pos > 0 && value < p) return 8'hFF;
      return digit_seg((value / p) % 10);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic scan_check(input int n);
      int pos;
      logic [DIGITS-1:0] ean;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         pos = (ncyc == 0) ? 0 : ((ncyc - 1) / SCAN_DIV) % DIGITS;
         ean = ~(DIGITS'(1) << pos);
         chk("an", 32'(an), 32'(ean));
         chk("seg", 32'(seg), 32'(exp_seg(mval, movf, lzb, pos)));
      end
   endtask

   task automatic wait_idle();
      int w;
      w = 0;
      while (busy && w < 50) begin
         @(negedge clk);
         w++;
      end
      chk("idle_wait", 32'(busy), 32'd0);
   endtask

   task automatic do_load(input int v);
      int bc;
      int snap;
      @(negedge clk);
      wait_idle();
      snap = done_cnt;
      bin_in = BIN_W'(v);
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      bc = 0;
      while (busy && bc < 100) begin
         bc++;
         @(negedge clk);
      end
      chk("busy_len", 32'(bc), 32'(BIN_W + 1));
      chk("done_pulse", 32'(done), 32'd1);
      mval = v;
      movf = (v >= 10000);
      chk("overflow", 32'(overflow), 32'(movf));
      @(negedge clk);
      chk("done_single", 32'(done), 32'd0);
      @(negedge clk);
      chk("done_count", 32'(done_cnt - snap), 32'd1);
   endtask

   initial begin
      int snap;
      int v;

      // Reset values
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
      chk("rst_an", 32'(an), 32'b1110);
      chk("rst_seg", 32'(seg), 32'hC0);
      rst_n = 1'b1;

      // Idle scan, all digits zero unblanked
      mval = 0;
      movf = 1'b0;
      scan_check(40);

      // 999 with blanking
      lzb = 1'b1;
      do_load(999);
      scan_check(16);

      // Overflow, then a normal value
      do_load(10000);
      scan_check(16);
      do_load(1234);
      scan_check(16);

      // Zero with blanking, then blanking off without reload
      do_load(0);
      scan_check(16);
      lzb = 1'b0;
      @(negedge clk);
      scan_check(16);

      // Random values and blanking modes, including the 9999/10000 edge
      for (int r = 0; r < 8; r++) begin
         v = (r == 0) ? 9999 : (r == 1) ? 10000 : int'($urandom_range(0, 16383));
         lzb = 1'($urandom_range(0, 1));
         do_load(v);
         scan_check(16);
      end

      // Second load during busy is dropped
      lzb = 1'b1;
      do_load(0);
      @(negedge clk);
      snap = done_cnt;
      bin_in = BIN_W'(1234);
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      @(negedge clk);
      bin_in = BIN_W'(5678);
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      wait_idle();
      repeat (25) @(negedge clk);
      chk("ignored_load_done", 32'(done_cnt - snap), 32'd1);
      chk("ignored_load_busy", 32'(busy), 32'd0);
      mval = 1234;
      movf = 1'b0;
      scan_check(16);

      // Reset during conversion
      snap = done_cnt;
      bin_in = BIN_W'(4321);
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      repeat (7) @(negedge clk);
      chk("midbusy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_ovf", 32'(overflow), 32'd0);
      chk("abort_an", 32'(an), 32'b1110);
      chk("abort_seg", 32'(seg), 32'hC0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      lzb = 1'b0;
      mval = 0;
      movf = 1'b0;
      scan_check(24);
      chk("abort_no_done", 32'(done_cnt - snap), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bcd_seg_scanner.md
# bcd_seg_scanner

Parametrised successor to the combinational BCD-to-segment decoder. Accepts a binary value on a load strobe, converts it to BCD sequentially by shift-and-add-3, and holds the digits in a display register. A time-multiplexed scanner then drives a common-anode seven-segment bank one digit at a time. It adds configurable digit count, leading-zero blanking, overflow indication and a busy/done handshake toward the keyboard/display datapath.

## Interface
- DIGITS, 4: number of display digits (1–8).
- BIN_W, 14: width of the binary input (≤ 32); 10**DIGITS must fit in 32 bits.
- SCAN_DIV, 50000: clock cycles each digit stays enabled (≥ 1).
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- bin_in  in  BIN_W  unsigned value to display, sampled on an accepted load.
- load  in  1  request; accepted only when busy=0.
- lzb  in  1  leading-zero blanking enable, sampled combinationally by the scanner.
- busy  out  1  conversion in progress.
- done  out  1  one-cycle pulse after the display register updates.
- overflow  out  1  last accepted value was ≥ 10**DIGITS.
- an  out  DIGITS  digit enables, active-low, one-hot-low.
- seg  out  8  {dp,g,f,e,d,c,b,a}, active-low; dp always 1.

## Operation
- FSM states: IDLE, SHIFT, COMMIT.
- IDLE: on load=1, capture bin_in into a shift register, clear the BCD accumulator (DIGITS×4 bits), set bit counter to BIN_W, compute ovf_next = (bin_in ≥ 10**DIGITS), go to SHIFT.
- SHIFT: each cycle, add 3 to every BCD nibble ≥ 5, then shift {bcd, bin} left by 1 and decrement the counter. After BIN_W shifts, go to COMMIT. Carries out of the top nibble are discarded; overflow is governed solely by ovf_next.
- COMMIT: write the BCD accumulator to the display register, load overflow ← ovf_next, go to IDLE.
- load is ignored while busy=1. No queueing.
- Scanner runs independently of the FSM. A prescaler counts 0..SCAN_DIV-1. At wrap, the digit index advances 0→1→…→DIGITS-1→0.
- Decode of the selected nibble: 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90. Nibbles > 9 cannot occur, so decode them to FF.
- overflow=1: every digit shows dash BF, regardless of lzb.
- lzb=1 and overflow=0: a digit at index i>0 shows FF when it and all digits above it are zero. Digit 0 is never blanked.
- an and seg are registered. They change one cycle after the index changes. an and seg always switch on the same edge, so no ghosting is allowed.

## Timing
- Reset values: state IDLE, busy 0, done 0, overflow 0, display register 0, prescaler 0, index 0, an = all 1s except bit0 = 0, seg = C0.
- Load accepted at edge E0. busy is high from E0 for exactly BIN_W+1 cycles, covering BIN_W SHIFT cycles plus COMMIT.
- The display register and overflow update at edge E(BIN_W+1), the same edge where busy falls. done is high for the single cycle after that edge.
- A new load is accepted in the first cycle busy=0, so back-to-back throughput is BIN_W+2 cycles.
- Display change appears on an/seg at the next registered output update after commit, within 1 cycle for the active digit.
- Reset asserted mid-conversion: aborts immediately and returns all state to reset values. A partial result is never committed.
- Load and reset released in the same cycle: load is ignored until the first edge with rst_n=1.

## Test plan
All scenarios use DIGITS=4, BIN_W=14, SCAN_DIV=4 unless stated.
1. Reset, then hold idle 40 cycles -> an cycles 1110,1101,1011,0111,1110, each held 4 cycles. seg = C0 on digit0; with lzb=0 all digits show C0.
2. Load 999, lzb=1 -> busy high 15 cycles, done pulses once. Digits 0–2 show 90, digit 3 shows FF, overflow=0.
3. Load 10000 -> overflow=1, all four digits show BF. Then load 1234 -> overflow=0; digits show 99, B0, A4, F9 for index 0..3.
4. Load 0 with lzb=1 -> digit0 C0, digits 1–3 FF. Toggle lzb=0 -> digits 1–3 C0 without a reload.
5. Load 1234, then pulse load with 5678 two cycles later -> second load ignored. Display 1234, exactly one done pulse.
6. Load 4321, assert rst_n=0 at cycle 8 of busy -> busy=0, done never pulses, display reads 0000 (C0 on digit0), an back to 1110.
